instrman_mo: RTL and testbench

//  Instruction-fetch manager with up to MAX_OUTS pipelined imem requests in flight and a BUF_DEPTH line buffer.

---
 rtl/instrman_mo_pkg.sv | 25 ++
 rtl/instrman_mo_if.sv | 37 +++
 rtl/instrman_mo_fifo.sv | 74 +++++++
 rtl/instrman_mo.sv | 125 ++++++++++++
 tb/tb_instrman_mo.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/instrman_mo_pkg.sv
// Shared defaults, width helpers and response classification for the instruction-fetch manager.
package instrman_mo_pkg;

  localparam int XLEN_D      = 32;
  localparam int BUS_LEN_D   = 2;
  localparam int MAX_OUTS_D  = 2;
  localparam int BUF_DEPTH_D = 4;
  localparam int RESET_PC_D  = 0;
  localparam int BUS_WID_D   = 32 * BUS_LEN_D;

  typedef enum logic [1:0] {
    RESP_NONE,
    RESP_DROP,
    RESP_LIVE
  } resp_kind_e;

  function automatic int cnt_bits(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/instrman_mo_if.sv
// imem bus, redirect and line-delivery signals of the fetch manager in one bundle.
interface instrman_mo_if
  import instrman_mo_pkg::*;
#(
  parameter int XLEN    = XLEN_D,
  parameter int BUS_WID = BUS_WID_D
);

  logic               imem_req;
  logic [XLEN-1:0]    imem_addr;
  logic               imem_gnt;
  logic [BUS_WID-1:0] imem_rdata;
  logic               imem_resp;
  logic               imem_err;
  logic               jump_vld;
  logic [XLEN-1:0]    jump_pc;
  logic               line_rdy;
  logic               line_vld;
  logic [BUS_WID-1:0] line_data;
  logic [XLEN-1:0]    line_addr;
  logic               line_err;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rdata, imem_resp, imem_err,
    input  jump_vld, jump_pc, line_rdy,
    output line_vld, line_data, line_addr, line_err
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rdata, imem_resp, imem_err,
    output jump_vld, jump_pc, line_rdy,
    input  line_vld, line_data, line_addr, line_err
  );

endinterface

// File: rtl/instrman_mo_fifo.sv
// Circular FIFO with same-cycle push/pop and a flush that discards everything except a coincident push.
module instrman_mo_fifo
  import instrman_mo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           head,
  output logic [cnt_bits(DEPTH)-1:0] count
);

  localparam int AW = ptr_bits(DEPTH);
  localparam int CW = cnt_bits(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == LAST) ? '0 : p + AW'(1);
  endfunction

  // A flush jumps the read pointer onto the write pointer, so a push in the same cycle survives.
  always_comb begin
    do_pop  = pop & ~flush & (cnt_q != '0);
    do_push = push & (flush | (int'(cnt_q) < DEPTH) | do_pop);
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    if (flush) begin
      rd_d  = wr_q;
      cnt_d = '0;
    end
    if (do_pop) begin
      rd_d  = bump(rd_q);
      cnt_d = cnt_d - CW'(1);
    end
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = bump(wr_q);
      cnt_d       = cnt_d + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/instrman_mo.sv
// Pipelined instruction-fetch manager: credit-limited imem requests, stale-response dropping
// after jumps, and a line buffer tagging each delivered line with its fetch address.
module instrman_mo
  import instrman_mo_pkg::*;
#(
  parameter int              XLEN      = XLEN_D,
  parameter int              BUS_LEN   = BUS_LEN_D,
  parameter int              MAX_OUTS  = MAX_OUTS_D,
  parameter int              BUF_DEPTH = BUF_DEPTH_D,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_D)
) (
  input logic           clk,
  input logic           rst,
  instrman_mo_if.master bus
);

  localparam int BUS_WID = 32 * BUS_LEN;
  localparam int OW      = cnt_bits(MAX_OUTS);
  localparam int BCW     = cnt_bits(BUF_DEPTH);
  localparam int LW      = BUS_WID + XLEN + 1;
  localparam logic [XLEN-1:0] LINE_BYTES = XLEN'(4 * BUS_LEN);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(LINE_BYTES - XLEN'(1));

  logic [XLEN-1:0] pc_q, pc_d;
  logic [OW-1:0]   drop_q, drop_d;
  logic            err_stop_q, err_stop_d;

  logic [XLEN-1:0] fetch_addr, line_base, resp_addr;
  logic [OW-1:0]   outs, live_eff;
  logic [BCW-1:0]  buf_cnt, cnt_eff;
  logic            err_eff, req, issue, line_vld, line_pop;
  logic [LW-1:0]   line_head;
  resp_kind_e      resp_kind;

  // A jump clears the credit view: everything buffered or in flight is about to become stale.
  always_comb begin
    fetch_addr = bus.jump_vld ? bus.jump_pc : pc_q;
    line_base  = fetch_addr & ALIGN_MASK;
    err_eff    = err_stop_q & ~bus.jump_vld;
    cnt_eff    = bus.jump_vld ? '0 : buf_cnt;
    live_eff   = bus.jump_vld ? '0 : outs - drop_q;
    req        = rst & ~err_eff & (int'(outs) < MAX_OUTS)
               & ((int'(cnt_eff) + int'(live_eff)) < BUF_DEPTH);
    issue      = req & bus.imem_gnt;
    if (!bus.imem_resp) begin
      resp_kind = RESP_NONE;
    end else if (bus.jump_vld || (drop_q != '0)) begin
      resp_kind = RESP_DROP;
    end else begin
      resp_kind = RESP_LIVE;
    end
  end

  always_comb begin
    pc_d       = pc_q;
    drop_d     = drop_q;
    err_stop_d = err_stop_q;
    if (issue) begin
      pc_d = line_base + LINE_BYTES;
    end else if (bus.jump_vld) begin
      pc_d = bus.jump_pc;
    end
    if (bus.jump_vld) begin
      drop_d     = outs - OW'(bus.imem_resp);
      err_stop_d = 1'b0;
    end else begin
      if (resp_kind == RESP_DROP) begin
        drop_d = drop_q - OW'(1);
      end
      if ((resp_kind == RESP_LIVE) && bus.imem_err) begin
        err_stop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      drop_q     <= '0;
      err_stop_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      err_stop_q <= err_stop_d;
    end
  end

  always @(posedge clk) begin
    if (rst && bus.imem_resp) begin
      assert (outs != '0);
    end
  end

  // Address FIFO occupancy is exactly the number of accepted-but-unanswered requests.
  instrman_mo_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTS)) u_addr_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (issue),
    .pop   (bus.imem_resp),
    .flush (1'b0),
    .din   (line_base),
    .head  (resp_addr),
    .count (outs)
  );

  assign line_vld = rst & (buf_cnt != '0);
  assign line_pop = line_vld & bus.line_rdy;

  instrman_mo_fifo #(.WIDTH(LW), .DEPTH(BUF_DEPTH)) u_line_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (resp_kind == RESP_LIVE),
    .pop   (line_pop),
    .flush (bus.jump_vld),
    .din   ({bus.imem_rdata, resp_addr, bus.imem_err}),
    .head  (line_head),
    .count (buf_cnt)
  );

  assign bus.imem_req  = req;
  assign bus.imem_addr = line_base;
  assign bus.line_vld  = line_vld;
  assign {bus.line_data, bus.line_addr, bus.line_err} = line_head;

endmodule

// File: tb/tb_instrman_mo.sv
// Directed scenarios plus a random phase, checked against a transaction-level model of the fetcher.
module tb_instrman_mo;
  import instrman_mo_pkg::*;

  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } flight_t;

  typedef struct {
    logic [BUS_WID_D-1:0] data;
    logic [31:0]          addr;
    logic                 err;
  } line_t;

  localparam logic [31:0] LINE_BYTES = 32'(4 * BUS_LEN_D);
  localparam logic [31:0] MASK       = ~(LINE_BYTES - 32'd1);

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  int   issues_seen = 0;

  flight_t     fq[$];
  line_t       bq[$];
  logic [31:0] m_pc;
  bit          m_err;
  bit          exp_req, exp_vld;
  logic [31:0] exp_addr;
  line_t       exp_head;

  always #5 clk = ~clk;

  instrman_mo_if bus ();

  instrman_mo dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Fetcher outputs implied by the model state and the inputs currently driven.
  task automatic computeExp();
    int live;
    live = 0;
    foreach (fq[i]) if (!fq[i].stale) live++;
    exp_addr = (bus.jump_vld ? bus.jump_pc : m_pc) & MASK;
    if (!rst) begin
      exp_req = 1'b0;
      exp_vld = 1'b0;
    end else begin
      exp_req = !(m_err && !bus.jump_vld) && (fq.size() < MAX_OUTS_D)
              && ((bus.jump_vld ? 0 : bq.size() + live) < BUF_DEPTH_D);
      exp_vld = bq.size() > 0;
    end
    if (bq.size() > 0) exp_head = bq[0];
  endtask

  task automatic checkOutput();
    computeExp();
    checkValue("req", 64'(bus.imem_req), 64'(exp_req));
    if (rst) checkValue("imem_addr", 64'(bus.imem_addr), 64'(exp_addr));
    checkValue("line_vld", 64'(bus.line_vld), 64'(exp_vld));
    if (exp_vld) begin
      checkValue("line_data", bus.line_data, exp_head.data);
      checkValue("line_addr", 64'(bus.line_addr), 64'(exp_head.addr));
      checkValue("line_err", 64'(bus.line_err), 64'(exp_head.err));
    end
    if (bus.imem_req && bus.imem_gnt) issues_seen++;
  endtask

  task automatic modelUpdate();
    bit      issue;
    flight_t f;
    line_t   l;
    computeExp();
    if (!rst) begin
      fq.delete();
      bq.delete();
      m_pc  = 32'(RESET_PC_D);
      m_err = 1'b0;
      return;
    end
    issue = exp_req && bus.imem_gnt;
    if (exp_vld && bus.line_rdy && !bus.jump_vld) void'(bq.pop_front());
    if (bus.imem_resp && fq.size() > 0) begin
      f = fq.pop_front();
      if (!bus.jump_vld && !f.stale) begin
        l.data = bus.imem_rdata;
        l.addr = f.addr;
        l.err  = bus.imem_err;
        bq.push_back(l);
        if (bus.imem_err) m_err = 1'b1;
      end
    end
    if (bus.jump_vld) begin
      foreach (fq[i]) fq[i].stale = 1'b1;
      bq.delete();
      m_err = 1'b0;
    end
    if (issue) begin
      f.addr  = exp_addr;
      f.stale = 1'b0;
      fq.push_back(f);
      m_pc = exp_addr + LINE_BYTES;
    end else if (bus.jump_vld) begin
      m_pc = bus.jump_pc;
    end
  endtask

  task automatic applyStimulus(input bit r, input bit gnt, input bit resp, input bit err,
                               input bit jv, input logic [31:0] jpc, input bit rdy);
    bit resp_eff;
    resp_eff       = resp && (!r || fq.size() > 0);
    rst            = r;
    bus.imem_gnt   = gnt;
    bus.imem_resp  = resp_eff;
    bus.imem_err   = err && resp_eff;
    bus.jump_vld   = jv;
    bus.jump_pc    = jpc;
    bus.line_rdy   = rdy;
    bus.imem_rdata = {$urandom, $urandom};
  endtask

  task automatic checkAt();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic advance();
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  task automatic step();
    checkAt();
    advance();
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    step();
  endtask

  initial begin
    // Reset with sequential fetch and immediate responses.
    doReset();
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      checkAt();
      checkValue("s1_addr", 64'(bus.imem_addr), 64'(k * 8));
      if (k >= 2) begin
        checkValue("s1_vld", 64'(bus.line_vld), 64'd1);
        checkValue("s1_laddr", 64'(bus.line_addr), 64'((k - 2) * 8));
      end
      advance();
    end

    // Outstanding limit, then buffer credit limit.
    doReset();
    issues_seen = 0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      step();
    end
    checkValue("s2_issues_outs", 64'(issues_seen), 64'd2);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      step();
    end
    for (int k = 0; k < 7; k++) begin
      applyStimulus(1'b1, 1'b1, k >= 2, 1'b0, 1'b0, 32'h0, 1'b0);
      step();
    end
    checkValue("s2_issues_credit", 64'(issues_seen), 64'd4);

    // Jump with two requests in flight.
    doReset();
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      step();
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h104, 1'b0);
    checkAt();
    checkValue("s3_jump_addr", 64'(bus.imem_addr), 64'h100);
    advance();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      step();
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkAt();
    checkValue("s3_vld", 64'(bus.line_vld), 64'd1);
    checkValue("s3_laddr", 64'(bus.line_addr), 64'h100);
    advance();

    // Jump coincident with the only response.
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h200, 1'b0);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkAt();
    checkValue("s4_vld", 64'(bus.line_vld), 64'd0);
    checkValue("s4_req", 64'(bus.imem_req), 64'd1);
    checkValue("s4_addr", 64'(bus.imem_addr), 64'h200);
    advance();

    // Bus error stops fetching until the next jump.
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h20, 1'b0);
    step();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    step();
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      checkAt();
      checkValue("s5_err", 64'(bus.line_err), 64'd1);
      checkValue("s5_laddr", 64'(bus.line_addr), 64'h20);
      checkValue("s5_req_stop", 64'(bus.imem_req), 64'd0);
      advance();
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
    checkAt();
    checkValue("s5_req_jump", 64'(bus.imem_req), 64'd1);
    checkValue("s5_addr_jump", 64'(bus.imem_addr), 64'h40);
    advance();

    // Near-full buffer with simultaneous pop and live push, then reset mid-burst.
    doReset();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      step();
    end
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      step();
    end
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      checkAt();
      checkValue("s6_rst_req", 64'(bus.imem_req), 64'd0);
      checkValue("s6_rst_vld", 64'(bus.line_vld), 64'd0);
      advance();
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    checkAt();
    checkValue("s6_post_vld", 64'(bus.line_vld), 64'd0);
    checkValue("s6_post_addr", 64'(bus.imem_addr), 64'(RESET_PC_D));
    advance();

    // Random traffic with occasional jumps, bus errors and resets.
    for (int n = 0; n < 3000; n++) begin
      applyStimulus($urandom_range(0, 299) != 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 11) == 0, $urandom, $urandom_range(0, 2) != 0);
      step();
    end

    $display("[TB] directed and random phases complete");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
